// File: rtl/pps_interval_monitor.sv
// PPS interval monitor: synchronizes an external PPS, measures clk cycles between rising edges and tracks lock.
// Define PPS_MONITOR_JITTER_EN to add running min/max of accepted intervals (intervalMin/intervalMax).
module pps_interval_monitor #(
  parameter int unsigned CLK_RATE    = 100000000,
  parameter int unsigned TOLERANCE   = 100,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ppsIn,
  output logic                   ppsStrobe,
  output logic [COUNT_WIDTH-1:0] clkRate,
  output logic                   clkRateStrobe,
  output logic                   ppsValid,
  output logic                   ppsMissing,
  output logic [15:0]            badIntervalCount
`ifdef PPS_MONITOR_JITTER_EN
  ,
  output logic [COUNT_WIDTH-1:0] intervalMin,
  output logic [COUNT_WIDTH-1:0] intervalMax
`endif
);

  localparam logic [COUNT_WIDTH:0] LOW_LIMIT  = (COUNT_WIDTH+1)'(CLK_RATE - TOLERANCE);
  localparam logic [COUNT_WIDTH:0] HIGH_LIMIT = (COUNT_WIDTH+1)'(CLK_RATE + TOLERANCE);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, FAULT} state_t;

  state_t                 state_q;
  logic                   sync1_q, sync2_q, delay_q, strobe_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] clkRate_q;
  logic                   rateStrobe_q, valid_q, missing_q;
  logic [15:0]            badCount_q, badCount_d;
  logic [COUNT_WIDTH:0]   measured;
  logic                   inRange, expired, judging, accept, reject;

  // Two-flop synchronizer plus one delay flop; the strobe itself is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      delay_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= ppsIn;
      sync2_q  <= sync1_q;
      delay_q  <= sync2_q;
      strobe_q <= sync2_q & ~delay_q;
    end
  end

  // Measured is one wider than the counter so a saturated counter cannot wrap into range.
  assign measured = {1'b0, count_q} + (COUNT_WIDTH+1)'(1);
  assign inRange  = (measured >= LOW_LIMIT) && (measured <= HIGH_LIMIT);
  assign expired  = measured > HIGH_LIMIT;
  assign judging  = (state_q == ARMED) || (state_q == LOCKED);
  assign accept   = judging && strobe_q && inRange;
  assign reject   = judging && strobe_q && !inRange;

  always_comb begin
    count_d = count_q;
    if (strobe_q) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  assign badCount_d = (badCount_q == 16'hFFFF) ? badCount_q : badCount_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Lock state machine; every status output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clkRate_q    <= '0;
      rateStrobe_q <= 1'b0;
      valid_q      <= 1'b0;
      missing_q    <= 1'b0;
      badCount_q   <= '0;
    end else begin
      rateStrobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strobe_q) state_q <= ARMED;
        end
        ARMED, LOCKED: begin
          if (accept) begin
            state_q      <= LOCKED;
            clkRate_q    <= measured[COUNT_WIDTH-1:0];
            rateStrobe_q <= 1'b1;
            valid_q      <= 1'b1;
          end else if (reject) begin
            state_q    <= FAULT;
            badCount_q <= badCount_d;
            valid_q    <= 1'b0;
          end else if (expired) begin
            state_q   <= FAULT;
            missing_q <= 1'b1;
            valid_q   <= 1'b0;
          end
        end
        FAULT: begin
          if (strobe_q) begin
            state_q   <= ARMED;
            missing_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PPS_MONITOR_JITTER_EN
  logic [COUNT_WIDTH-1:0] min_q, max_q;
  logic [COUNT_WIDTH-1:0] measuredTrim;

  assign measuredTrim = measured[COUNT_WIDTH-1:0];

  // The interval that takes ARMED into LOCKED seeds both extremes.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (accept) begin
      if (state_q == ARMED) begin
        min_q <= measuredTrim;
        max_q <= measuredTrim;
      end else begin
        if (measuredTrim < min_q) min_q <= measuredTrim;
        if (measuredTrim > max_q) max_q <= measuredTrim;
      end
    end
  end

  assign intervalMin = min_q;
  assign intervalMax = max_q;
`endif

  assign ppsStrobe        = strobe_q;
  assign clkRate          = clkRate_q;
  assign clkRateStrobe    = rateStrobe_q;
  assign ppsValid         = valid_q;
  assign ppsMissing       = missing_q;
  assign badIntervalCount = badCount_q;

endmodule
